udp_tx_arbiter: RTL and testbench

Per-packet round-robin scheduler that shares the single fixed-length UDP transmit engine between two byte-stream requesters, for example order-response and market-data echo. It grants one source per UDP packet and forwards that source's bytes into the engine's FIFO-side input. It gates the engine's transmit enable and enforces an inter-packet gap. It sits between the two source FIFOs and the UDP TX engine, whose payload length is fixed and zero-padded.

---
 rtl/udp_tx_pkg.sv | 28 ++
 rtl/udp_tx_rr_pick.sv | 28 ++
 rtl/udp_tx_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : udp_tx_pkg
//  Brief    : Shared encodings and defaults for the UDP TX arbiter and the
//             UDP TX engine (which consumes the same payload length).
//  Revision : 1.0  initial release
// ============================================================================
package udp_tx_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_GAP    = 2'd3
    } udp_tx_state_t;

    // Fixed engine payload length; bytes forwarded per packet never exceed it
    localparam int c_payload_bytes = 960;
    // Idle cycles enforced between packets
    localparam int c_ifg_cycles    = 12;
    // Width of the statistics counters
    localparam int c_stat_w        = 16;
    // Width of the per-packet byte counter (covers up to 2047 bytes)
    localparam int c_byte_cnt_w    = 11;

endpackage
`default_nettype wire

// File: rtl/udp_tx_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : udp_tx_rr_pick
//  Brief    : Two-input round-robin selector. A lone requester always wins;
//             on a tie the source that was not granted last wins.
//  Revision : 1.0  initial release
// ============================================================================
module udp_tx_rr_pick
    import udp_tx_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_s1,
    output logic [1:0] grant
);

    // One-hot pick from the request pair and the last-grant pointer
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_s1 ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/udp_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : udp_tx_arbiter
//  Brief    : Per-packet round-robin scheduler sharing one fixed-length UDP
//             TX engine between two byte-stream sources. Grants one source
//             per packet, forwards its bytes combinationally, gates the
//             engine transmit enable and enforces an inter-packet gap.
//             Optional statistics counters: define UDP_TX_ARB_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module udp_tx_arbiter
    import udp_tx_pkg::*;
#(
    parameter int PAYLOAD_BYTES = c_payload_bytes,
    parameter int IFG_CYCLES    = c_ifg_cycles
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          s0_tdata,
    input  logic                s0_tvalid,
    input  logic                s0_tlast,
    output logic                s0_tready,
    input  logic [7:0]          s1_tdata,
    input  logic                s1_tvalid,
    input  logic                s1_tlast,
    output logic                s1_tready,
    output logic [7:0]          m_fifo_tdata,
    output logic                m_fifo_tvalid,
    input  logic                m_fifo_tready,
    output logic                o_enable_tx,
    input  logic                i_pkt_done,
    input  logic                i_tx_allow,
    output logic [1:0]          o_grant,
    output logic                o_busy,
    output logic [c_stat_w-1:0] o_pkt_count,
    output logic [c_stat_w-1:0] o_split_count
);

    localparam logic [c_byte_cnt_w-1:0] c_last_idx  = c_byte_cnt_w'(PAYLOAD_BYTES - 1);
    // With no gap configured a finished packet returns straight to IDLE
    localparam udp_tx_state_t           c_post_done = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;

    udp_tx_state_t           r_state, w_state_nxt;
    logic [1:0]              r_grant, w_grant_nxt;
    logic                    r_last_s1, w_last_s1_nxt;
    logic                    r_fwd_open, w_fwd_open_nxt;
    logic [c_byte_cnt_w-1:0] r_byte_cnt, w_byte_cnt_nxt;

    logic [1:0] w_pick;
    logic       w_fwd;
    logic       w_sel_valid;
    logic       w_sel_last;
    logic [7:0] w_sel_data;
    logic       w_accept;
    logic       w_at_limit;
    logic       w_gap_zero;

    udp_tx_rr_pick u_rr_pick (
        .req     ({s1_tvalid, s0_tvalid}),
        .last_s1 (r_last_s1),
        .grant   (w_pick)
    );

    // Source mux driven by the registered grant; zero latency through it
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = 8'h00;
        if (r_grant[0]) begin
            w_sel_valid = s0_tvalid;
            w_sel_last  = s0_tlast;
            w_sel_data  = s0_tdata;
        end else if (r_grant[1]) begin
            w_sel_valid = s1_tvalid;
            w_sel_last  = s1_tlast;
            w_sel_data  = s1_tdata;
        end
    end

    assign w_fwd         = (r_state == ST_STREAM) & r_fwd_open;
    assign m_fifo_tdata  = w_sel_data;
    assign m_fifo_tvalid = w_sel_valid & w_fwd;
    assign s0_tready     = r_grant[0] & w_fwd & m_fifo_tready;
    assign s1_tready     = r_grant[1] & w_fwd & m_fifo_tready;
    assign w_accept      = m_fifo_tvalid & m_fifo_tready;
    assign w_at_limit    = w_accept & (r_byte_cnt == c_last_idx);
    assign o_grant       = r_grant;

    // Gap timer: preloaded outside GAP, counts down while in GAP
    generate
        if (IFG_CYCLES > 0) begin : g_gap
            localparam int c_gap_w = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
            logic [c_gap_w-1:0] r_gap_cnt;

            // Countdown of the remaining idle cycles
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_gap_cnt <= '0;
                end else if (r_state != ST_GAP) begin
                    r_gap_cnt <= c_gap_w'(IFG_CYCLES - 1);
                end else if (r_gap_cnt != '0) begin
                    r_gap_cnt <= r_gap_cnt - c_gap_w'(1);
                end
            end

            assign w_gap_zero = (r_gap_cnt == '0);
        end else begin : g_no_gap
            assign w_gap_zero = 1'b1;
        end
    endgenerate

    // Next-state, grant, forwarding window and engine-facing status
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_last_s1_nxt  = r_last_s1;
        w_fwd_open_nxt = r_fwd_open;
        w_byte_cnt_nxt = r_byte_cnt;
        o_enable_tx    = 1'b0;
        o_busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_busy         = 1'b0;
                w_byte_cnt_nxt = '0;
                w_fwd_open_nxt = 1'b1;
                if (i_tx_allow && (s0_tvalid || s1_tvalid)) begin
                    w_grant_nxt   = w_pick;
                    w_last_s1_nxt = w_pick[1];
                    w_state_nxt   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                o_enable_tx = 1'b1;
                if (w_accept) begin
                    w_byte_cnt_nxt = r_byte_cnt + c_byte_cnt_w'(1);
                end
                // Engine padded out while the source stalled: packet is over
                if (i_pkt_done) begin
                    w_fwd_open_nxt = 1'b0;
                    w_grant_nxt    = 2'b00;
                    w_state_nxt    = c_post_done;
                end else if (w_accept && (w_sel_last || w_at_limit)) begin
                    w_fwd_open_nxt = 1'b0;
                    w_state_nxt    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_enable_tx = 1'b1;
                if (i_pkt_done) begin
                    w_grant_nxt = 2'b00;
                    w_state_nxt = c_post_done;
                end
            end
            ST_GAP: begin
                if (w_gap_zero) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    // State, grant and forwarding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= 2'b00;
            r_last_s1  <= 1'b1;
            r_fwd_open <= 1'b0;
            r_byte_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_last_s1  <= w_last_s1_nxt;
            r_fwd_open <= w_fwd_open_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
        end
    end

`ifdef UDP_TX_ARB_STATS_EN
    logic                w_done_ok;
    logic                w_split_ev;
    logic [c_stat_w-1:0] r_pkt_count;
    logic [c_stat_w-1:0] r_split_count;

    assign w_done_ok  = i_pkt_done & ((r_state == ST_STREAM) | (r_state == ST_DRAIN));
    // A packet is split when it closes without the source's tlast byte
    assign w_split_ev = (r_state == ST_STREAM) &
                        (i_pkt_done ? ~(w_accept & w_sel_last)
                                    : (w_at_limit & ~w_sel_last));

    // Wrapping packet and split statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_count   <= '0;
            r_split_count <= '0;
        end else begin
            if (w_done_ok) begin
                r_pkt_count <= r_pkt_count + c_stat_w'(1);
            end
            if (w_split_ev) begin
                r_split_count <= r_split_count + c_stat_w'(1);
            end
        end
    end

    assign o_pkt_count   = r_pkt_count;
    assign o_split_count = r_split_count;
`else
    assign o_pkt_count   = '0;
    assign o_split_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_udp_tx_arbiter
//  Brief    : Self-checking bench for udp_tx_arbiter with source models, a
//             byte scoreboard and a scripted engine (i_pkt_done pulses).
//  Revision : 1.0  initial release
// ============================================================================
module tb_udp_tx_arbiter;

`ifdef UDP_TX_ARB_STATS_EN
    localparam bit c_stats = 1'b1;
`else
    localparam bit c_stats = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s0_tdata = 8'h00, s1_tdata = 8'h00;
    logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic        s0_tlast = 1'b0, s1_tlast = 1'b0;
    logic        s0_tready, s1_tready;
    logic [7:0]  m_fifo_tdata;
    logic        m_fifo_tvalid;
    logic        m_fifo_tready = 1'b1;
    logic        o_enable_tx;
    logic        i_pkt_done = 1'b0;
    logic        i_tx_allow = 1'b1;
    logic [1:0]  o_grant;
    logic        o_busy;
    logic [15:0] o_pkt_count, o_split_count;

    udp_tx_arbiter #(.PAYLOAD_BYTES(960), .IFG_CYCLES(12)) dut (
        .clk(clk), .rst(rst),
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .m_fifo_tdata(m_fifo_tdata), .m_fifo_tvalid(m_fifo_tvalid), .m_fifo_tready(m_fifo_tready),
        .o_enable_tx(o_enable_tx), .i_pkt_done(i_pkt_done), .i_tx_allow(i_tx_allow),
        .o_grant(o_grant), .o_busy(o_busy),
        .o_pkt_count(o_pkt_count), .o_split_count(o_split_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [8:0] src0_q[$];
    logic [8:0] src1_q[$];
    logic [8:0] exp_q[$];
    int   sent0 = 0, sent1 = 0;
    int   stall0 = -1;
    int   fwd_cnt = 0;
    int   ex_pkt = 0, ex_split = 0;
    bit   bp_en = 1'b0;
    logic [8:0] mon_e;

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic set_valid();
        s0_tvalid = (src0_q.size() > 0) && !(stall0 >= 0 && sent0 >= stall0);
        s0_tdata  = (src0_q.size() > 0) ? src0_q[0][7:0] : 8'h00;
        s0_tlast  = (src0_q.size() > 0) ? src0_q[0][8]   : 1'b0;
        s1_tvalid = (src1_q.size() > 0);
        s1_tdata  = (src1_q.size() > 0) ? src1_q[0][7:0] : 8'h00;
        s1_tlast  = (src1_q.size() > 0) ? src1_q[0][8]   : 1'b0;
    endtask

    task automatic push_src(input bit src, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            logic [8:0] b;
            b = {(i == n - 1), 8'(base + i)};
            if (src) src1_q.push_back(b);
            else     src0_q.push_back(b);
        end
        set_valid();
    endtask

    task automatic push_exp(input bit src, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({src, 8'(base + i)});
        end
    endtask

    task automatic flush_model();
        src0_q.delete(); src1_q.delete(); exp_q.delete();
        sent0 = 0; sent1 = 0; stall0 = -1; fwd_cnt = 0;
        ex_pkt = 0; ex_split = 0; i_pkt_done = 1'b0;
        set_valid();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        flush_model();
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_fwd(input int n, output bit ok);
        int k = 0;
        while (fwd_cnt < n && k < 20000) begin tick(); k++; end
        ok = (fwd_cnt >= n);
    endtask

    task automatic wait_grant(output bit ok);
        int k = 0;
        while (o_grant == 2'b00 && k < 200) begin tick(); k++; end
        ok = (o_grant != 2'b00);
    endtask

    task automatic pulse_done();
        i_pkt_done = 1'b1;
        tick();
        i_pkt_done = 1'b0;
    endtask

    // Waits for n bytes, lets the window settle, records the count, ends the packet
    task automatic run_pkt(input int n, output bit ok, output int got);
        wait_fwd(n, ok);
        repeat (3) tick();
        got = fwd_cnt;
        fwd_cnt = 0;
        pulse_done();
        ex_pkt++;
    endtask

    // Source models: pop a byte after each handshake seen at the edge
    initial begin
        logic t0, t1;
        forever begin
            @(negedge clk);
            t0 = s0_tvalid & s0_tready;
            t1 = s1_tvalid & s1_tready;
            @(posedge clk); #1;
            if (t0 && src0_q.size() > 0) begin void'(src0_q.pop_front()); sent0++; end
            if (t1 && src1_q.size() > 0) begin void'(src1_q.pop_front()); sent1++; end
            m_fifo_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
            set_valid();
        end
    end

    // Scoreboard: every forwarded byte must be the next expected {source, data}
    always @(negedge clk) begin
        if (!rst && m_fifo_tvalid && m_fifo_tready) begin
            fwd_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL fwd_unexpected got src=%0d data=%02h, none expected", o_grant[1], m_fifo_tdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({o_grant[1], m_fifo_tdata} !== mon_e) begin
                    errors++;
                    $display("FAIL fwd_byte got src=%0d data=%02h, want src=%0d data=%02h",
                             o_grant[1], m_fifo_tdata, mon_e[8], mon_e[7:0]);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (o_grant !== 2'b00)     begin errors++; $display("FAIL rst_grant got=%b want=00", o_grant); end
        checks++; if (o_enable_tx !== 1'b0)  begin errors++; $display("FAIL rst_enable got=%b want=0", o_enable_tx); end
        checks++; if (m_fifo_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got=%b want=0", m_fifo_tvalid); end
        checks++; if ({s1_tready, s0_tready} !== 2'b00) begin errors++; $display("FAIL rst_tready got=%b want=00", {s1_tready, s0_tready}); end
        checks++; if (o_busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got=%b want=0", o_busy); end
        checks++; if (o_pkt_count !== 16'd0) begin errors++; $display("FAIL rst_pkt got=%0d want=0", o_pkt_count); end
        checks++; if (o_split_count !== 16'd0) begin errors++; $display("FAIL rst_split got=%0d want=0", o_split_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok; int got; int n;
        bp_en = 1'b1;
        push_src(0, 100, 16); push_exp(0, 100, 16);
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL single_pre_grant got=%b want=00", o_grant); end
        tick();
        checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL single_grant got=%b want=01", o_grant); end
        wait_fwd(100, ok);
        repeat (3) tick();
        checks++; if (fwd_cnt !== 100) begin errors++; $display("FAIL single_count got=%0d want=100", fwd_cnt); end
        checks++; if ({o_enable_tx, s0_tready, m_fifo_tvalid} !== 3'b100)
            begin errors++; $display("FAIL single_drain got en/rdy/vld=%b want=100", {o_enable_tx, s0_tready, m_fifo_tvalid}); end
        bp_en = 1'b0;
        push_src(0, 10, 128); push_exp(0, 10, 128);
        fwd_cnt = 0;
        pulse_done(); ex_pkt++;
        checks++; if (o_pkt_count !== (c_stats ? 16'(ex_pkt) : 16'd0)) begin errors++; $display("FAIL single_pkt_cnt got=%0d want=%0d", o_pkt_count, c_stats ? ex_pkt : 0); end
        checks++; if (o_split_count !== 16'd0) begin errors++; $display("FAIL single_split_cnt got=%0d want=0", o_split_count); end
        n = 0;
        while (!o_enable_tx && n < 100) begin n++; tick(); end
        checks++; if (n !== 13) begin errors++; $display("FAIL single_ifg got=%0d cycles want=13", n); end
        checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL single_regrant got=%b want=01", o_grant); end
        run_pkt(10, ok, got);
        checks++; if (!ok || got !== 10) begin errors++; $display("FAIL single_second got=%0d want=10", got); end
    endtask

    task automatic test_rr();
        bit ok; int got;
        logic [1:0] want [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        apply_reset();
        push_src(0, 10, 0);  push_src(0, 10, 64);
        push_src(1, 10, 32); push_src(1, 10, 96);
        push_exp(0, 10, 0);  push_exp(1, 10, 32);
        push_exp(0, 10, 64); push_exp(1, 10, 96);
        for (int k = 0; k < 4; k++) begin
            wait_grant(ok);
            checks++; if (!ok || o_grant !== want[k]) begin errors++; $display("FAIL rr_grant%0d got=%b want=%b", k, o_grant, want[k]); end
            run_pkt(10, ok, got);
            checks++; if (!ok || got !== 10) begin errors++; $display("FAIL rr_len%0d got=%0d want=10", k, got); end
        end
        checks++; if (o_pkt_count !== (c_stats ? 16'(ex_pkt) : 16'd0)) begin errors++; $display("FAIL rr_pkt_cnt got=%0d want=%0d", o_pkt_count, c_stats ? ex_pkt : 0); end
    endtask

    task automatic test_split();
        bit ok; int got;
        bp_en = 1'b1;
        push_src(1, 1500, 0); push_exp(1, 1500, 0);
        wait_grant(ok);
        checks++; if (!ok || o_grant !== 2'b10) begin errors++; $display("FAIL split_grant got=%b want=10", o_grant); end
        wait_fwd(960, ok);
        repeat (3) tick();
        checks++; if (fwd_cnt !== 960) begin errors++; $display("FAIL split_first_len got=%0d want=960", fwd_cnt); end
        checks++; if ({s1_tvalid, s1_tready} !== 2'b10) begin errors++; $display("FAIL split_byte961 got vld/rdy=%b want=10", {s1_tvalid, s1_tready}); end
        ex_split++;
        checks++; if (o_split_count !== (c_stats ? 16'(ex_split) : 16'd0)) begin errors++; $display("FAIL split_cnt got=%0d want=%0d", o_split_count, c_stats ? ex_split : 0); end
        fwd_cnt = 0;
        pulse_done(); ex_pkt++;
        wait_grant(ok);
        checks++; if (!ok || o_grant !== 2'b10) begin errors++; $display("FAIL split_regrant got=%b want=10", o_grant); end
        run_pkt(540, ok, got);
        checks++; if (!ok || got !== 540) begin errors++; $display("FAIL split_second_len got=%0d want=540", got); end
        bp_en = 1'b0;
    endtask

    task automatic test_stall();
        bit ok; int got;
        stall0 = sent0 + 50;
        push_src(0, 80, 48); push_exp(0, 80, 48);
        wait_grant(ok);
        checks++; if (!ok || o_grant !== 2'b01) begin errors++; $display("FAIL stall_grant got=%b want=01", o_grant); end
        wait_fwd(50, ok);
        repeat (4) tick();
        checks++; if (fwd_cnt !== 50 || m_fifo_tvalid !== 1'b0 || o_enable_tx !== 1'b1)
            begin errors++; $display("FAIL stall_hold got cnt=%0d vld=%b en=%b want 50/0/1", fwd_cnt, m_fifo_tvalid, o_enable_tx); end
        fwd_cnt = 0;
        pulse_done(); ex_pkt++; ex_split++;
        checks++; if (o_enable_tx !== 1'b0) begin errors++; $display("FAIL stall_close got en=%b want=0", o_enable_tx); end
        checks++; if (o_split_count !== (c_stats ? 16'(ex_split) : 16'd0)) begin errors++; $display("FAIL stall_split got=%0d want=%0d", o_split_count, c_stats ? ex_split : 0); end
        stall0 = -1;
        set_valid();
        wait_grant(ok);
        checks++; if (!ok || o_grant !== 2'b01) begin errors++; $display("FAIL stall_regrant got=%b want=01", o_grant); end
        run_pkt(30, ok, got);
        checks++; if (!ok || got !== 30) begin errors++; $display("FAIL stall_rest got=%0d want=30", got); end
    endtask

    task automatic test_allow();
        bit ok; int got;
        i_tx_allow = 1'b0;
        push_src(0, 5, 96); push_exp(0, 5, 96);
        repeat (20) tick();
        checks++; if ({o_grant, o_enable_tx, o_busy} !== 4'b0000)
            begin errors++; $display("FAIL allow_blocked got grant/en/busy=%b want=0000", {o_grant, o_enable_tx, o_busy}); end
        i_tx_allow = 1'b1;
        checks++; if (o_grant !== 2'b00) begin errors++; $display("FAIL allow_same_cycle got=%b want=00", o_grant); end
        tick();
        checks++; if (o_grant !== 2'b01) begin errors++; $display("FAIL allow_grant got=%b want=01", o_grant); end
        run_pkt(5, ok, got);
        checks++; if (!ok || got !== 5) begin errors++; $display("FAIL allow_len got=%0d want=5", got); end
    endtask

    task automatic test_reset_mid();
        bit ok; int got;
        push_src(0, 400, 0); push_exp(0, 400, 0);
        wait_grant(ok);
        checks++; if (!ok || o_grant !== 2'b01) begin errors++; $display("FAIL rmid_grant got=%b want=01", o_grant); end
        wait_fwd(300, ok);
        checks++; if (!ok || fwd_cnt !== 300 || m_fifo_tvalid !== 1'b1)
            begin errors++; $display("FAIL rmid_stream got cnt=%0d vld=%b want 300/1", fwd_cnt, m_fifo_tvalid); end
        rst = 1'b1;
        #1;
        checks++; if ({o_grant, o_enable_tx, m_fifo_tvalid, s0_tready, s1_tready, o_busy} !== 7'd0)
            begin errors++; $display("FAIL rmid_outputs got=%b want=0000000", {o_grant, o_enable_tx, m_fifo_tvalid, s0_tready, s1_tready, o_busy}); end
        checks++; if ({o_pkt_count, o_split_count} !== 32'd0)
            begin errors++; $display("FAIL rmid_counters got pkt=%0d split=%0d want 0/0", o_pkt_count, o_split_count); end
        flush_model();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        push_src(0, 10, 144); push_src(1, 10, 160);
        push_exp(0, 10, 144); push_exp(1, 10, 160);
        wait_grant(ok);
        checks++; if (!ok || o_grant !== 2'b01) begin errors++; $display("FAIL rmid_first got=%b want=01", o_grant); end
        run_pkt(10, ok, got);
        wait_grant(ok);
        checks++; if (!ok || o_grant !== 2'b10) begin errors++; $display("FAIL rmid_second got=%b want=10", o_grant); end
        run_pkt(10, ok, got);
        checks++; if (o_pkt_count !== (c_stats ? 16'(ex_pkt) : 16'd0)) begin errors++; $display("FAIL rmid_pkt_cnt got=%0d want=%0d", o_pkt_count, c_stats ? ex_pkt : 0); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_split();
        test_stall();
        test_allow();
        test_reset_mid();
        repeat (3) tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
